// File: rtl/apb_regbank_slave.sv
// APB4 slave in front of a bank of NUM_REGS registers, with programmable wait states,
// PSLVERR on bad decode or read-only writes, read-only masking and per-register write pulses.
module apb_regbank_slave #(
    parameter int                      DATA_W      = 32,
    parameter int                      ADDR_W      = 16,
    parameter int                      NUM_REGS    = 16,
    parameter logic [7:0]              BASE_ADDR   = 8'h02,
    parameter int                      WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
    parameter logic [DATA_W-1:0]       RESET_VAL   = '0
) (
    input  logic                         PCLK,
    input  logic                         Preset,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic                         PSELx,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    input  logic [DATA_W/8-1:0]          PSTRB,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int         NB      = DATA_W / 8;
    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rdy_set, rdy_clr, commit;

    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [DATA_W-1:0] ro_arr [NUM_REGS];

    logic [7:0]        idx;
    logic [IDX_W-1:0]  sidx;
    logic              sel_err, idx_err, ro_err, err;
    logic [DATA_W-1:0] rd_val;
    logic              unused_addr;

    assign idx         = PADDR[15:8];
    assign sidx        = idx[IDX_W-1:0];
    assign unused_addr = ^PADDR;

    // Address decode; sidx is only trusted once idx_err is known to be clear.
    always_comb begin
        sel_err = (PADDR[7:0] != BASE_ADDR);
        idx_err = ({1'b0, idx} >= 9'(NUM_REGS));
        ro_err  = !idx_err && PWRITE && RO_MASK[sidx];
        err     = sel_err || idx_err || ro_err;
        rd_val  = RO_MASK[sidx] ? ro_arr[sidx] : regs[sidx];
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            ro_arr[i] = ro_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs[i];
        end
    end

    always_ff @(posedge PCLK or posedge Preset) begin
        if (Preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_set = 1'b0;
        rdy_clr = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    rdy_set = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    // Master abandoned the transfer: drop it without a commit.
                    state_d = IDLE;
                    cnt_d   = '0;
                    rdy_clr = 1'b1;
                end else if (PREADY) begin
                    if (PENABLE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rdy_clr = 1'b1;
                        commit  = PWRITE && !err;
                    end
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    rdy_set = (cnt_q == WS_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge Preset) begin
        if (Preset) begin
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_pulse <= '0;
            if (rdy_set) begin
                PREADY  <= 1'b1;
                PSLVERR <= err;
                if (err) begin
                    PRDATA <= '0;
                end else if (!PWRITE) begin
                    PRDATA <= rd_val;
                end
            end else if (rdy_clr) begin
                PREADY  <= 1'b0;
                PSLVERR <= 1'b0;
            end
            if (commit) begin
                for (int b = 0; b < NB; b++) begin
                    if (PSTRB[b]) begin
                        regs[sidx][8*b +: 8] <= PWDATA[8*b +: 8];
                    end
                end
                if (|PSTRB) begin
                    wr_pulse[sidx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench: slave A (no wait states, register 2 read-only) and slave B (3 wait states)
// share one APB bus with separate selects.
module tb_apb_regbank_slave;

    logic          PCLK = 1'b0;
    logic          Preset;
    logic [15:0]   PADDR;
    logic          psel_a, psel_b;
    logic          PENABLE, PWRITE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [511:0]  ro_data;

    logic [31:0]   prdata_a, prdata_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b;
    logic [511:0]  reg_q_a, reg_q_b;
    logic [15:0]   wr_pulse_a, wr_pulse_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    apb_regbank_slave #(.WAIT_STATES(0), .RO_MASK(16'h0004)) dut_a (
        .PCLK(PCLK), .Preset(Preset), .PADDR(PADDR), .PSELx(psel_a), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .ro_data(ro_data), .reg_q(reg_q_a), .wr_pulse(wr_pulse_a)
    );

    apb_regbank_slave #(.WAIT_STATES(3)) dut_b (
        .PCLK(PCLK), .Preset(Preset), .PADDR(PADDR), .PSELx(psel_b), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .ro_data(ro_data), .reg_q(reg_q_b), .wr_pulse(wr_pulse_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return reg_q_a[i*32 +: 32];
    endfunction

    function automatic logic [31:0] qb(input int i);
        return reg_q_b[i*32 +: 32];
    endfunction

    // One full transfer, starting at the setup cycle; returns at completion edge + 1.
    task automatic xfer(input bit which, input logic [15:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] st, input bit keep,
                        output logic [31:0] rd, output logic err, output int cyc,
                        output logic [31:0] q_pre);
        int ri;
        ri      = int'(addr[11:8]);
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wd;
        PSTRB   = st;
        PENABLE = 1'b0;
        if (which) psel_b = 1'b1; else psel_a = 1'b1;
        cyc = 1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc = 2;
        while (!(which ? pready_b : pready_a) && cyc < 40) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        rd    = which ? prdata_b : prdata_a;
        err   = which ? pslverr_b : pslverr_a;
        q_pre = which ? qb(ri) : qa(ri);
        @(posedge PCLK); #1;
        PENABLE = 1'b0;
        if (!keep) begin
            psel_a = 1'b0;
            psel_b = 1'b0;
        end
    endtask

    logic [31:0] rd, qp;
    logic        er;
    int          cy;

    initial begin
        Preset  = 1'b1;
        PADDR   = '0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PWDATA  = '0;
        PSTRB   = '0;
        ro_data = '0;
        ro_data[2*32 +: 32] = 32'hDEADBEEF;
        repeat (3) @(posedge PCLK);
        #1 Preset = 1'b0;

        chk("rst pready", {31'd0, pready_a}, 32'd0);
        chk("rst pslverr", {31'd0, pslverr_a}, 32'd0);
        chk("rst prdata", prdata_a, 32'h0);
        chk("rst wr_pulse", {16'd0, wr_pulse_a}, 32'h0);
        chk("rst reg5", qa(5), 32'h0);

        // Plain read with no wait states
        xfer(0, 16'h0302, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("rd3 cycles", cy, 32'd2);
        chk("rd3 data", rd, 32'h0);
        chk("rd3 err", {31'd0, er}, 32'd0);

        // Byte-strobed write and pulse
        xfer(0, 16'h0502, 1, 32'hA1B2C3D4, 4'b0101, 0, rd, er, cy, qp);
        chk("wr5 cycles", cy, 32'd2);
        chk("wr5 err", {31'd0, er}, 32'd0);
        chk("wr5 pulse", {16'd0, wr_pulse_a}, 32'h0000_0020);
        chk("wr5 reg", qa(5), 32'h00B200D4);
        @(posedge PCLK); #1;
        chk("wr5 pulse gone", {16'd0, wr_pulse_a}, 32'h0);
        xfer(0, 16'h0502, 0, 32'h0, 4'hF, 0, rd, er, cy, qp);
        chk("rd5 data", rd, 32'h00B200D4);
        xfer(0, 16'h0502, 1, 32'h11223344, 4'b1010, 0, rd, er, cy, qp);
        chk("wr5b reg", qa(5), 32'h11B233D4);
        xfer(0, 16'h0502, 1, 32'hFFFFFFFF, 4'b0000, 0, rd, er, cy, qp);
        chk("strb0 err", {31'd0, er}, 32'd0);
        chk("strb0 pulse", {16'd0, wr_pulse_a}, 32'h0);
        chk("strb0 reg", qa(5), 32'h11B233D4);

        // Read-only register 2
        xfer(0, 16'h0202, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("ro rd data", rd, 32'hDEADBEEF);
        chk("ro rd err", {31'd0, er}, 32'd0);
        chk("ro reg_q", qa(2), 32'h0);
        xfer(0, 16'h0202, 1, 32'h12345678, 4'hF, 0, rd, er, cy, qp);
        chk("ro wr err", {31'd0, er}, 32'd1);
        chk("ro wr prdata", rd, 32'h0);
        chk("ro wr pulse", {16'd0, wr_pulse_a}, 32'h0);
        chk("ro wr pslverr clr", {31'd0, pslverr_a}, 32'd0);
        xfer(0, 16'h0202, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("ro rd again", rd, 32'hDEADBEEF);

        // Decode errors
        xfer(0, 16'h0502, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("pre err rd5", rd, 32'h11B233D4);
        xfer(0, 16'h1002, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("idx16 rd err", {31'd0, er}, 32'd1);
        chk("idx16 rd data", rd, 32'h0);
        chk("idx16 cycles", cy, 32'd2);
        xfer(0, 16'h1002, 1, 32'hFFFFFFFF, 4'hF, 0, rd, er, cy, qp);
        chk("idx16 wr err", {31'd0, er}, 32'd1);
        chk("idx16 wr pulse", {16'd0, wr_pulse_a}, 32'h0);
        xfer(0, 16'h0303, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("base rd err", {31'd0, er}, 32'd1);
        chk("base rd data", rd, 32'h0);
        xfer(0, 16'h0503, 1, 32'h0, 4'hF, 0, rd, er, cy, qp);
        chk("base wr err", {31'd0, er}, 32'd1);
        chk("base wr reg5", qa(5), 32'h11B233D4);

        // Wait states on slave B
        xfer(1, 16'h0702, 1, 32'h12345678, 4'hF, 0, rd, er, cy, qp);
        chk("ws cycles", cy, 32'd5);
        chk("ws err", {31'd0, er}, 32'd0);
        chk("ws reg before commit", qp, 32'h0);
        chk("ws pulse", {16'd0, wr_pulse_b}, 32'h0000_0080);
        chk("ws reg", qb(7), 32'h12345678);
        xfer(1, 16'h0702, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("ws rd cycles", cy, 32'd5);
        chk("ws rd data", rd, 32'h12345678);

        // Master drops PSELx mid-access
        PADDR = 16'h0802; PWRITE = 1'b1; PWDATA = 32'hAAAA5555; PSTRB = 4'hF;
        PENABLE = 1'b0; psel_b = 1'b1;
        @(posedge PCLK); #1;
        psel_b = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        chk("abort pready", {31'd0, pready_b}, 32'd0);
        chk("abort pulse", {16'd0, wr_pulse_b}, 32'h0);
        chk("abort reg", qb(8), 32'h0);

        // Reset while a wait-state write is about to complete
        PADDR = 16'h0902; PWRITE = 1'b1; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        PENABLE = 1'b0; psel_b = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("mid pready before rst", {31'd0, pready_b}, 32'd1);
        Preset = 1'b1;
        #1;
        chk("mid rst pready", {31'd0, pready_b}, 32'd0);
        chk("mid rst reg9", qb(9), 32'h0);
        @(posedge PCLK); #1;
        Preset = 1'b0; PENABLE = 1'b0; psel_b = 1'b0;
        @(posedge PCLK); #1;
        chk("post rst pulse", {16'd0, wr_pulse_b}, 32'h0);
        chk("post rst reg9", qb(9), 32'h0);
        chk("post rst reg5 a", qa(5), 32'h0);

        // Back-to-back write then read, no idle cycle
        xfer(0, 16'h0402, 1, 32'h55AA55AA, 4'hF, 1, rd, er, cy, qp);
        chk("b2b wr cycles", cy, 32'd2);
        chk("b2b wr err", {31'd0, er}, 32'd0);
        xfer(0, 16'h0402, 0, 32'h0, 4'h0, 0, rd, er, cy, qp);
        chk("b2b rd cycles", cy, 32'd2);
        chk("b2b rd data", rd, 32'h55AA55AA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
